// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states and the
// registered data-memory request bundle.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dmem_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the LSU: legality check, store lane replication
// and byte enables, and load shift/extension of the returned word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_addr_lo,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_value
);

  logic        size_ok;
  logic        aligned;
  logic [31:0] shifted;

  // Unsigned variants exist only for loads, so they are size-legal only with read.
  always_comb begin
    size_ok = 1'b0;
    aligned = 1'b0;
    case (funct3)
      F3_B:    begin size_ok = 1'b1; aligned = 1'b1;              end
      F3_H:    begin size_ok = 1'b1; aligned = ~addr_lo[0];       end
      F3_W:    begin size_ok = 1'b1; aligned = (addr_lo == 2'b00); end
      F3_BU:   begin size_ok = read; aligned = 1'b1;              end
      F3_HU:   begin size_ok = read; aligned = ~addr_lo[0];       end
      default: begin size_ok = 1'b0; aligned = 1'b0;              end
    endcase
    legal = (read ^ write) & size_ok & aligned;
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << addr_lo;
      end
      default: begin
        wdata = store_data;
        be    = 4'b1111;
      end
    endcase
  end

  always_comb begin
    shifted = rdata >> {load_addr_lo, 3'b000};
    case (load_funct3)
      F3_B:    load_value = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_value = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_value = {24'h000000, shifted[7:0]};
      F3_HU:   load_value = {16'h0000, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: captures a legal load/store, runs the request/grant/response
// handshake with a timeout, and returns the extended load value.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] STORE_DATA,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  output logic        STALL,
  output logic [31:0] LOAD_DATA,
  output logic        LSU_FAULT,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic        DMEM_GNT,
  input  logic        DMEM_RVALID,
  input  logic [31:0] DMEM_RDATA
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t        state;
  dmem_req_t         dreq;
  logic              dmem_req_q;
  logic              fault_q;
  logic              abort_q;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [1:0]        addr_lo_q;
  logic [31:0]       load_data_q;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              legal;
  logic              start;
  logic              timeout_hit;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic [31:0]       load_value;

  lsu_align u_align (
    .read         (MEM_READ),
    .write        (MEM_WRITE),
    .funct3       (FUNCT3),
    .addr_lo      (ADDR[1:0]),
    .store_data   (STORE_DATA),
    .load_funct3  (funct3_q),
    .load_addr_lo (addr_lo_q),
    .rdata        (DMEM_RDATA),
    .legal        (legal),
    .wdata        (wdata),
    .be           (be),
    .load_value   (load_value)
  );

  // The cycle after a timeout still sees the aborted instruction; abort_q keeps it from restarting.
  assign start       = (state == IDLE) & ~abort_q & legal;
  assign timeout_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    case (state)
      IDLE:    STALL = start;
      REQ:     STALL = 1'b1;
      WAIT:    STALL = 1'b1;
      default: STALL = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      dreq        <= '0;
      dmem_req_q  <= 1'b0;
      fault_q     <= 1'b0;
      abort_q     <= 1'b0;
      is_load_q   <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      load_data_q <= 32'h0000_0000;
      tmo_cnt     <= '0;
    end else begin
      fault_q <= 1'b0;
      abort_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dreq       <= '{we: MEM_WRITE, addr: {ADDR[31:2], 2'b00}, wdata: wdata, be: be};
            dmem_req_q <= 1'b1;
            is_load_q  <= MEM_READ;
            funct3_q   <= FUNCT3;
            addr_lo_q  <= ADDR[1:0];
            tmo_cnt    <= '0;
            state      <= REQ;
          end else if (!abort_q && (MEM_READ || MEM_WRITE)) begin
            fault_q <= 1'b1;
          end
        end
        REQ: begin
          if (DMEM_GNT) begin
            dmem_req_q <= 1'b0;
            tmo_cnt    <= '0;
            state      <= is_load_q ? WAIT : DONE;
          end else if (timeout_hit) begin
            dmem_req_q <= 1'b0;
            fault_q    <= 1'b1;
            abort_q    <= 1'b1;
            state      <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (DMEM_RVALID) begin
            load_data_q <= load_value;
            state       <= DONE;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            abort_q <= 1'b1;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign LOAD_DATA  = load_data_q;
  assign LSU_FAULT  = fault_q;
  assign DMEM_REQ   = dmem_req_q;
  assign DMEM_WE    = dreq.we;
  assign DMEM_ADDR  = dreq.addr;
  assign DMEM_WDATA = dreq.wdata;
  assign DMEM_BE    = dreq.be;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TMO = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] ADDR = 32'h0;
  logic [31:0] STORE_DATA = 32'h0;
  logic        MEM_READ = 1'b0;
  logic        MEM_WRITE = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic        STALL;
  logic [31:0] LOAD_DATA;
  logic        LSU_FAULT;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_BE;
  logic        DMEM_GNT = 1'b0;
  logic        DMEM_RVALID = 1'b0;
  logic [31:0] DMEM_RDATA = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .STORE_DATA(STORE_DATA),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .FUNCT3(FUNCT3),
    .STALL(STALL), .LOAD_DATA(LOAD_DATA), .LSU_FAULT(LSU_FAULT),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_GNT(DMEM_GNT),
    .DMEM_RVALID(DMEM_RVALID), .DMEM_RDATA(DMEM_RDATA)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total = 0;
  logic [31:0] exp_load;

  // Observations of the last access
  int          o_stall, o_req, o_fault;
  bit          o_done;
  logic [31:0] o_addr, o_wdata, o_load;
  logic [3:0]  o_be;
  logic        o_we;

  function automatic bit model_legal(bit rd, bit wr, int f3, int unsigned a);
    int bytes;
    if (rd == wr) return 1'b0;
    if (wr && f3 > 2) return 1'b0;
    if (rd && !(f3 inside {0, 1, 2, 4, 5})) return 1'b0;
    bytes = 1 << (f3 % 4);
    return (a % bytes) == 0;
  endfunction

  function automatic logic [31:0] model_load(int f3, int unsigned a, int unsigned rdata);
    longint v;
    v = longint'(rdata >> (8 * (a % 4)));
    case (f3)
      0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      4: v = v % 256;
      5: v = v % 65536;
      default: v = v;
    endcase
    return 32'(v);
  endfunction

  // Presents one instruction like the core would, models the memory, records observations.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int gnt_wait, input logic [31:0] rdata);
    logic gnt_prev;
    @(posedge CLK); #1;
    o_stall = 0; o_req = 0; o_fault = 0; o_done = 1'b0;
    o_addr = 32'h0; o_wdata = 32'h0; o_be = 4'h0; o_we = 1'b0;
    MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDR = a; STORE_DATA = d;
    for (int k = 0; k < 64 && !o_done; k++) begin
      @(negedge CLK);
      if (LSU_FAULT) o_fault++;
      gnt_prev = DMEM_GNT;
      DMEM_RVALID = gnt_prev & rd;
      DMEM_RDATA = (gnt_prev & rd) ? rdata : $urandom;
      if (DMEM_REQ) begin
        o_req++;
        o_addr = DMEM_ADDR; o_wdata = DMEM_WDATA; o_be = DMEM_BE; o_we = DMEM_WE;
        DMEM_GNT = (o_req > gnt_wait);
      end else begin
        DMEM_GNT = 1'b0;
      end
      if (!STALL) o_done = 1'b1;
      else o_stall++;
    end
    @(posedge CLK); #1;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0; DMEM_GNT = 1'b0; DMEM_RVALID = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      if (LSU_FAULT) o_fault++;
      if (DMEM_REQ) o_req++;
    end
    o_load = LOAD_DATA;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    total++; if (STALL !== 1'b0) $display("FAIL reset_stall: got %b expected 0", STALL); else passed++;
    total++; if (LOAD_DATA !== 32'h0) $display("FAIL reset_load: got %h expected 0", LOAD_DATA); else passed++;
    total++; if (LSU_FAULT !== 1'b0) $display("FAIL reset_fault: got %b expected 0", LSU_FAULT); else passed++;
    total++; if ({DMEM_REQ, DMEM_WE, DMEM_BE} !== 6'b0) $display("FAIL reset_req: got %b expected 0", {DMEM_REQ, DMEM_WE, DMEM_BE}); else passed++;
    total++; if ({DMEM_ADDR, DMEM_WDATA} !== 64'h0) $display("FAIL reset_bus: got %h expected 0", {DMEM_ADDR, DMEM_WDATA}); else passed++;
    exp_load = 32'h0;
  endtask

  task automatic test_store_word();
    do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0);
    total++; if (o_stall !== 2) $display("FAIL sw_stall: got %0d expected 2", o_stall); else passed++;
    total++; if (o_addr !== 32'h100) $display("FAIL sw_addr: got %h expected 00000100", o_addr); else passed++;
    total++; if (o_be !== 4'b1111) $display("FAIL sw_be: got %b expected 1111", o_be); else passed++;
    total++; if (o_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata); else passed++;
    total++; if (o_we !== 1'b1) $display("FAIL sw_we: got %b expected 1", o_we); else passed++;
    total++; if (o_fault !== 0) $display("FAIL sw_fault: got %0d expected 0", o_fault); else passed++;
  endtask

  task automatic test_store_byte();
    do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 32'h0);
    total++; if (o_be !== 4'b1000) $display("FAIL sb_be: got %b expected 1000", o_be); else passed++;
    total++; if (o_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata: got %h expected a5a5a5a5", o_wdata); else passed++;
    total++; if (o_addr !== 32'h100) $display("FAIL sb_addr: got %h expected 00000100", o_addr); else passed++;
  endtask

  task automatic test_loads();
    do_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 0, 32'h12F07856);
    total++; if (o_load !== 32'hFFFFFFF0) $display("FAIL lb_data: got %h expected fffffff0", o_load); else passed++;
    total++; if (o_stall !== 3) $display("FAIL lb_stall: got %0d expected 3", o_stall); else passed++;
    total++; if (o_we !== 1'b0) $display("FAIL lb_we: got %b expected 0", o_we); else passed++;
    do_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 0, 32'h12F07856);
    total++; if (o_load !== 32'h000000F0) $display("FAIL lbu_data: got %h expected 000000f0", o_load); else passed++;
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h12F07856);
    total++; if (o_load !== 32'h000012F0) $display("FAIL lh_data: got %h expected 000012f0", o_load); else passed++;
    exp_load = 32'h000012F0;
  endtask

  task automatic test_illegal();
    do_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hFFFFFFFF);
    total++; if (o_fault !== 1) $display("FAIL lw_mis_fault: got %0d expected 1", o_fault); else passed++;
    total++; if (o_req !== 0) $display("FAIL lw_mis_req: got %0d expected 0", o_req); else passed++;
    total++; if (o_stall !== 0) $display("FAIL lw_mis_stall: got %0d expected 0", o_stall); else passed++;
    do_access(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
    total++; if (o_fault !== 1 || o_req !== 0) $display("FAIL rw_both: got fault=%0d req=%0d expected 1/0", o_fault, o_req); else passed++;
    do_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
    total++; if (o_fault !== 1 || o_req !== 0) $display("FAIL f3_011: got fault=%0d req=%0d expected 1/0", o_fault, o_req); else passed++;
    total++; if (o_load !== exp_load) $display("FAIL illegal_load_kept: got %h expected %h", o_load, exp_load); else passed++;
  endtask

  task automatic test_timeout();
    do_access(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 1000, 32'h0);
    total++; if (o_fault !== 1) $display("FAIL tmo_fault: got %0d expected 1", o_fault); else passed++;
    total++; if (o_req !== TMO) $display("FAIL tmo_req_cycles: got %0d expected %0d", o_req, TMO); else passed++;
    total++; if (o_stall !== TMO + 1) $display("FAIL tmo_stall: got %0d expected %0d", o_stall, TMO + 1); else passed++;
    total++; if (o_done !== 1'b1) $display("FAIL tmo_hang: got %b expected 1", o_done); else passed++;
    total++; if (o_load !== exp_load) $display("FAIL tmo_load_kept: got %h expected %h", o_load, exp_load); else passed++;
  endtask

  task automatic test_random();
    bit rd, wr, lg;
    int sel, g;
    logic [2:0] f3;
    logic [31:0] a, d, rdat, ew;
    logic [3:0] eb;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      rd = (sel <= 3) || (sel == 8);
      wr = (sel >= 4 && sel <= 8);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom; d = $urandom; rdat = $urandom;
      g = $urandom_range(0, 3);
      lg = model_legal(rd, wr, int'(f3), a);
      do_access(rd, wr, f3, a, d, g, rdat);
      if (!lg) begin
        total++; if (o_fault !== ((rd || wr) ? 1 : 0) || o_req !== 0 || o_stall !== 0)
          $display("FAIL rnd_illegal[%0d]: got fault=%0d req=%0d stall=%0d", i, o_fault, o_req, o_stall); else passed++;
      end else if (wr) begin
        case (f3)
          3'b000:  begin ew = (d % 256) * 32'h01010101;   eb = 4'(1 << (a % 4)); end
          3'b001:  begin ew = (d % 65536) * 32'h00010001; eb = 4'(3 << (a % 4)); end
          default: begin ew = d;                          eb = 4'hF;             end
        endcase
        total++; if (o_stall !== g + 2 || o_fault !== 0) $display("FAIL rnd_st_stall[%0d]: got %0d/%0d expected %0d/0", i, o_stall, o_fault, g + 2); else passed++;
        total++; if (o_addr !== a - (a % 4) || o_we !== 1'b1) $display("FAIL rnd_st_addr[%0d]: got %h expected %h", i, o_addr, a - (a % 4)); else passed++;
        total++; if (o_wdata !== ew || o_be !== eb) $display("FAIL rnd_st_lane[%0d]: got %h/%b expected %h/%b", i, o_wdata, o_be, ew, eb); else passed++;
      end else begin
        exp_load = model_load(int'(f3), a, rdat);
        total++; if (o_stall !== g + 3 || o_fault !== 0) $display("FAIL rnd_ld_stall[%0d]: got %0d/%0d expected %0d/0", i, o_stall, o_fault, g + 3); else passed++;
        total++; if (o_load !== exp_load) $display("FAIL rnd_ld_data[%0d]: got %h expected %h", i, o_load, exp_load); else passed++;
      end
      total++; if (LOAD_DATA !== exp_load) $display("FAIL rnd_load_hold[%0d]: got %h expected %h", i, LOAD_DATA, exp_load); else passed++;
    end
  endtask

  task automatic test_reset_mid_access();
    @(posedge CLK); #1;
    MEM_READ = 1'b1; FUNCT3 = 3'b010; ADDR = 32'h300;
    @(negedge CLK);
    @(negedge CLK);
    total++; if (DMEM_REQ !== 1'b1) $display("FAIL mid_req: got %b expected 1", DMEM_REQ); else passed++;
    DMEM_GNT = 1'b1;
    @(posedge CLK); #1;
    DMEM_GNT = 1'b0; RESET = 1'b1; MEM_READ = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0; DMEM_RVALID = 1'b1; DMEM_RDATA = 32'h00000055;
    @(negedge CLK);
    total++; if (STALL !== 1'b0) $display("FAIL mid_stall: got %b expected 0", STALL); else passed++;
    total++; if (LOAD_DATA !== 32'h0) $display("FAIL mid_load_reset: got %h expected 0", LOAD_DATA); else passed++;
    @(posedge CLK); #1;
    DMEM_RVALID = 1'b0;
    @(negedge CLK);
    total++; if (LOAD_DATA !== 32'h0) $display("FAIL mid_late_rvalid: got %h expected 0", LOAD_DATA); else passed++;
    total++; if ({DMEM_REQ, LSU_FAULT, STALL} !== 3'b000) $display("FAIL mid_idle: got %b expected 000", {DMEM_REQ, LSU_FAULT, STALL}); else passed++;
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage directly downstream of the ALU in the RISC-V core.
- Takes the ALU result as the effective address and rs2 as store data, then performs byte, half or word loads and stores to data memory over a request/grant/response handshake.
- Stalls the core until the access completes.
- Returns the sign- or zero-extended load value for writeback and flags misaligned or illegal accesses.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in REQ or WAIT before aborting with fault; must be ≥2.

Ports:
- CLK  input  1  single clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- ADDR  input  32  effective address (ALU_OUT).
- STORE_DATA  input  32  rs2 value.
- MEM_READ  input  1  load instruction present.
- MEM_WRITE  input  1  store instruction present.
- FUNCT3  input  3  instruction funct3: size/sign.
- STALL  output  1  hold PC/IF; 1 while an access is in progress.
- LOAD_DATA  output  32  extended load result, registered.
- LSU_FAULT  output  1  one-cycle pulse on misaligned, illegal or timed-out access.
- DMEM_REQ  output  1  memory request valid.
- DMEM_WE  output  1  1 = write.
- DMEM_ADDR  output  32  word address, i.e. {ADDR[31:2],2'b00}.
- DMEM_WDATA  output  32  lane-replicated store data.
- DMEM_BE  output  4  byte enables.
- DMEM_GNT  input  1  memory accepts the request this cycle.
- DMEM_RVALID  input  1  read data valid.
- DMEM_RDATA  input  32  read word.

Behaviour:
- Clocking and reset:
  - One clock, CLK. RESET is synchronous and active-high.
  - Reset values: state = IDLE, LOAD_DATA = 0, LSU_FAULT = 0, DMEM_REQ = 0, DMEM_WE = 0, DMEM_ADDR = 0, DMEM_WDATA = 0, DMEM_BE = 0, timeout counter = 0.
- STALL is combinational:
  - 1 in IDLE when a legal op is presented.
  - 1 throughout REQ and WAIT.
  - 0 in DONE.
- Legality, checked in IDLE:
  - Loads: FUNCT3 ∈ {LB 000, LH 001, LW 010, LBU 100, LHU 101}.
  - Stores: FUNCT3 ∈ {SB 000, SH 001, SW 010}.
  - Halfword requires ADDR[0] = 0; word requires ADDR[1:0] = 00.
  - MEM_READ and MEM_WRITE both high is illegal.
- States:
  - IDLE:
    - Legal op: capture ADDR, STORE_DATA, FUNCT3 and the op type into registers, go to REQ. STALL = 1 this cycle.
    - Illegal op: LSU_FAULT = 1 next cycle, no memory access, STALL = 0, stay in IDLE, LOAD_DATA unchanged.
    - A DMEM_RVALID arriving while in IDLE is ignored.
  - REQ:
    - DMEM_REQ = 1. DMEM_ADDR, DMEM_WE, DMEM_WDATA and DMEM_BE are driven from the captured registers and held stable until the grant.
    - DMEM_GNT = 1: a store goes to DONE; a load goes to WAIT.
  - WAIT:
    - DMEM_REQ = 0.
    - DMEM_RVALID = 1: LOAD_DATA ← extend(DMEM_RDATA >> 8*addr[1:0]), go to DONE.
    - GNT and RVALID in the same cycle while in REQ is not supported; memory returns data at least 1 cycle after grant.
  - DONE:
    - STALL = 0 for exactly one cycle; the core advances. Always returns to IDLE.
    - The same instruction is still present in this cycle and must not retrigger.
- Store alignment:
  - SB: WDATA = {4{b[7:0]}}, BE = 4'b0001 << addr[1:0].
  - SH: WDATA = {2{h[15:0]}}, BE = 4'b0011 << addr[1:0].
  - SW: WDATA = data, BE = 4'b1111.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Timeout:
  - The counter clears on entry to REQ or WAIT and increments each cycle spent in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES: LSU_FAULT pulse, DMEM_REQ = 0, go to IDLE. STALL = 0 on the following cycle; a load leaves LOAD_DATA unchanged.
- RESET mid-access forces IDLE at the next edge; a late DMEM_RVALID is ignored.
- Minimum latencies:
  - Store with 0-wait grant: 3 cycles (IDLE, REQ, DONE).
  - Load with grant in REQ and RVALID 1 cycle later: 4 cycles.

Decomposition:
- Shared package lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t {IDLE, REQ, WAIT, DONE}.
  - DMEM request struct (we, addr, wdata, be).
- One combinational sub-module lsu_align:
  - Store lane replication and byte enables.
  - Load shift and extend.
  - Legality check.
- FSM and registers live in load_store_unit.

Test Plan:
- SW ADDR = 0x100, STORE_DATA = 0xDEADBEEF, GNT on the first REQ cycle → DMEM_ADDR = 0x100, BE = 1111, WDATA = 0xDEADBEEF, WE = 1; STALL high 2 cycles, then low in DONE.
- SB ADDR = 0x103, data = 0x000000A5 → BE = 1000, WDATA = 0xA5A5A5A5, DMEM_ADDR = 0x100.
- LB ADDR = 0x102, RDATA = 0x12F07856 → LOAD_DATA = 0xFFFFFFF0. LBU at the same address → 0x000000F0. LH ADDR = 0x102 → 0x000012F0.
- LW ADDR = 0x102 → LSU_FAULT pulse, no DMEM_REQ, STALL = 0. MEM_READ = MEM_WRITE = 1 → fault. Load with FUNCT3 = 011 → fault.
- Load with DMEM_GNT held low for TIMEOUT_CYCLES = 16 → LSU_FAULT pulse, DMEM_REQ drops, return to IDLE, LOAD_DATA unchanged.
- RESET asserted in WAIT, then DMEM_RVALID = 1 with RDATA = 0x55 the next cycle → IDLE, LOAD_DATA = 0, STALL = 0; the response is ignored.
